// File: rtl/branch_target_predictor_if.sv
// Bundle of the fetch-lookup, execute-update and statistics signals that
// connect the branch target predictor to the pipelined core.
//
// Signals (direction as seen from the predictor, i.e. the slave side):
//   pc_f          in   fetch-stage PC
//   pred_taken_f  out  predicted taken
//   pred_pc_f     out  predicted next PC
//   upd_en_e      in   valid branch/JAL in E
//   upd_jump_e    in   instruction in E is JAL
//   upd_pc_e      in   PC of instruction in E
//   upd_taken_e   in   resolved outcome
//   upd_target_e  in   resolved target
//   pred_taken_e  in   prediction carried down to E
//   pred_pc_e     in   predicted PC carried down to E
//   mispredict_e  out  redirect required
//   redirect_pc_e out  correct next PC
//   branch_cnt    out  resolved branches/jumps counted
//   miss_cnt      out  mispredicts counted
interface branch_target_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  pc_f;
    logic             pred_taken_f;
    logic [XLEN-1:0]  pred_pc_f;
    logic             upd_en_e;
    logic             upd_jump_e;
    logic [XLEN-1:0]  upd_pc_e;
    logic             upd_taken_e;
    logic [XLEN-1:0]  upd_target_e;
    logic             pred_taken_e;
    logic [XLEN-1:0]  pred_pc_e;
    logic             mispredict_e;
    logic [XLEN-1:0]  redirect_pc_e;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] miss_cnt;

    // Core / hazard-unit side
    modport master (
        output pc_f, upd_en_e, upd_jump_e, upd_pc_e, upd_taken_e,
               upd_target_e, pred_taken_e, pred_pc_e,
        input  pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e,
               branch_cnt, miss_cnt
    );

    // Predictor side
    modport slave (
        input  pc_f, upd_en_e, upd_jump_e, upd_pc_e, upd_taken_e,
               upd_target_e, pred_taken_e, pred_pc_e,
        output pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e,
               branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// F stage: combinational lookup of pc_f gives pred_taken_f / pred_pc_f.
// E stage: the resolved branch/JAL updates the table at posedge and the
// combinational mispredict_e / redirect_pc_e tell the hazard unit to flush.
// Saturating statistics count resolved branches and mispredicts.
//
// Ports:
//   clk  single clock, all state changes on posedge
//   rst  synchronous active-high reset (clears valid/jump/ctr and counters)
//   bus  branch_target_predictor_if.slave carrying all F/E/statistics signals
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic             jump_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic             taken_f;

    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             mispredict;

    // PC bits [1:0] are always zero for word-aligned instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_f[1:0], bus.upd_pc_e[1:0]};

    // Fetch lookup: reads the registered table, so an update to the same
    // index in this cycle only becomes visible on the next cycle.
    always_comb begin
        idx_f   = bus.pc_f[IDX_W+1:2];
        tag_f   = bus.pc_f[XLEN-1:IDX_W+2];
        hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        taken_f = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
        bus.pred_taken_f = taken_f;
        bus.pred_pc_f    = taken_f ? target_q[idx_f] : bus.pc_f + XLEN'(4);
    end

    // Execute-stage resolution: compare the carried prediction against the
    // real outcome and produce the correct next PC.
    always_comb begin
        idx_e = bus.upd_pc_e[IDX_W+1:2];
        tag_e = bus.upd_pc_e[XLEN-1:IDX_W+2];
        hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        mispredict = bus.upd_en_e &&
                     ((bus.pred_taken_e != bus.upd_taken_e) ||
                      (bus.upd_taken_e && (bus.pred_pc_e != bus.upd_target_e)));
        bus.mispredict_e  = mispredict;
        bus.redirect_pc_e = bus.upd_taken_e ? bus.upd_target_e
                                            : bus.upd_pc_e + XLEN'(4);
    end

    // Table update. Tags and targets carry no reset; valid gates their use.
    // A miss that resolves not-taken leaves the table alone so cold branches
    // don't evict useful entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jump_q[i]  <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (bus.upd_en_e) begin
            if (hit_e) begin
                if (bus.upd_jump_e) begin
                    ctr_q[idx_e]    <= 2'b11;
                    jump_q[idx_e]   <= 1'b1;
                    target_q[idx_e] <= bus.upd_target_e;
                end else if (bus.upd_taken_e) begin
                    ctr_q[idx_e]    <= (ctr_q[idx_e] == 2'b11) ? 2'b11
                                                               : ctr_q[idx_e] + 2'b01;
                    target_q[idx_e] <= bus.upd_target_e;
                end else begin
                    ctr_q[idx_e]    <= (ctr_q[idx_e] == 2'b00) ? 2'b00
                                                               : ctr_q[idx_e] - 2'b01;
                end
            end else if (bus.upd_taken_e) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= bus.upd_target_e;
                jump_q[idx_e]   <= bus.upd_jump_e;
                ctr_q[idx_e]    <= bus.upd_jump_e ? 2'b11 : 2'b10;
            end
        end
    end

    // Statistics stick at all-ones instead of wrapping so a long run still
    // reads as "at least this many".
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (bus.upd_en_e && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign bus.branch_cnt = branch_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor. Narrow statistics
// counters let saturation be reached in a few cycles.
module tb_branch_target_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_target_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_target_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: one record per table slot, plus two statistics ints.
    bit        mValid  [ENTRIES];
    bit        mJump   [ENTRIES];
    bit [31:0] mTag    [ENTRIES];
    bit [31:0] mTarget [ENTRIES];
    int        mCtr    [ENTRIES];
    int        mBranch;
    int        mMiss;

    function automatic int idxOf(bit [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit [31:0] tagOf(bit [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit modelHit(bit [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
    endfunction

    function automatic bit modelTaken(bit [31:0] pc);
        return modelHit(pc) && (mJump[idxOf(pc)] || mCtr[idxOf(pc)] >= 2);
    endfunction

    function automatic bit [31:0] modelPc(bit [31:0] pc);
        return modelTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
    endfunction

    function automatic bit modelMispredict();
        if (!bus.upd_en_e) return 1'b0;
        return (bus.pred_taken_e != bus.upd_taken_e) ||
               (bus.upd_taken_e && (bus.pred_pc_e != bus.upd_target_e));
    endfunction

    function automatic bit [31:0] modelRedirect();
        return bus.upd_taken_e ? bus.upd_target_e : bus.upd_pc_e + 32'd4;
    endfunction

    task automatic modelUpdate();
        bit mis;
        int i;
        mis = modelMispredict();
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                mValid[k] = 0;
                mJump[k]  = 0;
                mCtr[k]   = 0;
            end
            mBranch = 0;
            mMiss   = 0;
        end else if (bus.upd_en_e) begin
            i = idxOf(bus.upd_pc_e);
            if (modelHit(bus.upd_pc_e)) begin
                if (bus.upd_jump_e) begin
                    mCtr[i] = 3;
                    mJump[i] = 1;
                    mTarget[i] = bus.upd_target_e;
                end else if (bus.upd_taken_e) begin
                    mCtr[i] = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
                    mTarget[i] = bus.upd_target_e;
                end else begin
                    mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
                end
            end else if (bus.upd_taken_e) begin
                mValid[i]  = 1;
                mTag[i]    = tagOf(bus.upd_pc_e);
                mTarget[i] = bus.upd_target_e;
                mJump[i]   = bus.upd_jump_e;
                mCtr[i]    = bus.upd_jump_e ? 3 : 2;
            end
            if (mBranch < CNT_MAX) mBranch++;
            if (mis && mMiss < CNT_MAX) mMiss++;
        end
    endtask

    // Commit one clock edge in both the DUT and the model.
    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    // Drive a full set of inputs away from the active edge.
    task automatic applyStimulus(input bit en, input bit jmp, input bit [31:0] pce,
                                 input bit tk, input bit [31:0] tgt, input bit pte,
                                 input bit [31:0] ppe, input bit [31:0] pcf);
        @(negedge clk);
        bus.upd_en_e     = en;
        bus.upd_jump_e   = jmp;
        bus.upd_pc_e     = pce;
        bus.upd_taken_e  = tk;
        bus.upd_target_e = tgt;
        bus.pred_taken_e = pte;
        bus.pred_pc_e    = ppe;
        bus.pc_f         = pcf;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic checkAll(input string tag);
        checkOutput({tag, "/pred_taken_f"}, 32'(bus.pred_taken_f), 32'(modelTaken(bus.pc_f)));
        checkOutput({tag, "/pred_pc_f"}, bus.pred_pc_f, modelPc(bus.pc_f));
        checkOutput({tag, "/mispredict_e"}, 32'(bus.mispredict_e), 32'(modelMispredict()));
        checkOutput({tag, "/redirect_pc_e"}, bus.redirect_pc_e, modelRedirect());
        checkOutput({tag, "/branch_cnt"}, 32'(bus.branch_cnt), 32'(mBranch));
        checkOutput({tag, "/miss_cnt"}, 32'(bus.miss_cnt), 32'(mMiss));
    endtask

    task automatic idle(input bit [31:0] pcf);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, pcf);
    endtask

    // Resolve a branch in E using the prediction F would have made for it.
    task automatic doUpdate(input bit [31:0] pc, input bit jmp, input bit tk,
                            input bit [31:0] tgt, input bit [31:0] pcf);
        applyStimulus(1, jmp, pc, tk, tgt, modelTaken(pc), modelPc(pc), pcf);
    endtask

    function automatic bit [31:0] randPc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
    endfunction

    bit outc [7] = '{0, 0, 1, 1, 1, 1, 0};
    bit expT [7] = '{0, 0, 0, 1, 1, 1, 1};

    initial begin
        bit        en, jmp, tk, pte;
        bit [31:0] pce, tgt, ppe, pcf;

        $display("[TB] start");
        // Reset and cold lookup
        rst = 1'b1;
        idle(32'h40);
        tick();
        tick();
        rst = 1'b0;
        idle(32'h40);
        checkOutput("reset_pred_taken", 32'(bus.pred_taken_f), 32'd0);
        checkOutput("reset_pred_pc", bus.pred_pc_f, 32'h44);
        checkOutput("reset_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        checkOutput("reset_miss_cnt", 32'(bus.miss_cnt), 32'd0);

        // Train 0x40 -> 0x80
        applyStimulus(1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 32'h100);
        checkOutput("train_mispredict", 32'(bus.mispredict_e), 32'd1);
        checkOutput("train_redirect", bus.redirect_pc_e, 32'h80);
        tick();
        idle(32'h40);
        checkOutput("train_pred_taken", 32'(bus.pred_taken_f), 32'd1);
        checkOutput("train_pred_pc", bus.pred_pc_f, 32'h80);
        checkOutput("train_branch_cnt", 32'(bus.branch_cnt), 32'd1);
        checkOutput("train_miss_cnt", 32'(bus.miss_cnt), 32'd1);

        // Counter walk: 10 ->01->00 ->01->10->11->11 ->10
        for (int k = 0; k < 7; k++) begin
            doUpdate(32'h40, 0, outc[k], 32'h80, 32'h100);
            checkAll("ctr_upd");
            tick();
            idle(32'h40);
            checkOutput($sformatf("ctr_step%0d", k), 32'(bus.pred_taken_f), 32'(expT[k]));
            checkAll("ctr_probe");
        end

        // Alias: 0x80 shares index 0 with 0x40
        doUpdate(32'h80, 0, 1, 32'h200, 32'h100);
        tick();
        idle(32'h40);
        checkOutput("alias_old_taken", 32'(bus.pred_taken_f), 32'd0);
        checkOutput("alias_old_pc", bus.pred_pc_f, 32'h44);
        idle(32'h80);
        checkOutput("alias_new_pc", bus.pred_pc_f, 32'h200);

        // Same-cycle lookup and update: old value this cycle, new next cycle
        doUpdate(32'h40, 0, 1, 32'h100, 32'h0);
        tick();
        doUpdate(32'h40, 0, 1, 32'h300, 32'h40);
        checkOutput("rbw_same_cycle", bus.pred_pc_f, 32'h100);
        tick();
        idle(32'h40);
        checkOutput("rbw_next_cycle", bus.pred_pc_f, 32'h300);

        // JAL at the top of the address space
        idle(32'hFFFF_FFFC);
        checkOutput("wrap_pred_taken", 32'(bus.pred_taken_f), 32'd0);
        checkOutput("wrap_pred_pc", bus.pred_pc_f, 32'h0);
        doUpdate(32'hFFFF_FFFC, 1, 1, 32'h1000, 32'h0);
        checkOutput("jal_mispredict", 32'(bus.mispredict_e), 32'd1);
        tick();
        idle(32'hFFFF_FFFC);
        checkOutput("jal_pred_pc", bus.pred_pc_f, 32'h1000);

        // Disabled update never flags mispredict
        applyStimulus(0, 0, 32'h40, 1, 32'h999, 0, 32'h0, 32'h40);
        checkOutput("noen_mispredict", 32'(bus.mispredict_e), 32'd0);
        tick();

        // Statistics saturation
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 0, 32'h200, 1, 32'h400, 0, 32'h204, 32'h0);
            tick();
        end
        idle(32'h0);
        checkOutput("sat_miss_cnt", 32'(bus.miss_cnt), 32'(CNT_MAX));
        checkOutput("sat_branch_cnt", 32'(bus.branch_cnt), 32'(CNT_MAX));
        applyStimulus(1, 0, 32'h200, 1, 32'h400, 0, 32'h204, 32'h0);
        checkOutput("sat_mispredict", 32'(bus.mispredict_e), 32'd1);
        tick();
        idle(32'h0);
        checkOutput("sat_miss_hold", 32'(bus.miss_cnt), 32'(CNT_MAX));

        // Reset in an update cycle drops the update and clears the table
        rst = 1'b1;
        applyStimulus(1, 0, 32'h40, 1, 32'h500, 0, 32'h44, 32'h40);
        tick();
        rst = 1'b0;
        idle(32'h40);
        checkOutput("rstupd_pred_taken", 32'(bus.pred_taken_f), 32'd0);
        checkOutput("rstupd_pred_pc", bus.pred_pc_f, 32'h44);
        checkOutput("rstupd_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        checkOutput("rstupd_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        idle(32'hFFFF_FFFC);
        checkOutput("rstupd_jal_cleared", bus.pred_pc_f, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 3) == 0);
            tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            pce = randPc();
            tgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) begin
                pte = modelTaken(pce);
                ppe = modelPc(pce);
            end else begin
                pte = 1'($urandom_range(0, 1));
                ppe = $urandom() & 32'hFFFF_FFFC;
            end
            pcf = ($urandom_range(0, 1) == 0) ? pce : randPc();
            applyStimulus(en, jmp, pce, tk, tgt, pte, ppe, pcf);
            checkAll("rand");
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
